// File: rtl/pca_axi_mmio_regbank.sv
// AXI-Lite slave register bank: N_REGS control slots with strobe merge, read-only status slots and per-slot write pulses.
// Optional PCA_MMIO_ERRCNT_EN adds a saturating SLVERR counter at slot N_REGS; responses 1 cycle after handshake, held until ready.
module pca_axi_mmio_regbank #(
   parameter int                 ADDR_W    = 32,
   parameter int                 DATA_W    = 32,
   parameter int                 N_REGS    = 16,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter logic [N_REGS-1:0]  RO_MASK   = '0,
   parameter logic [DATA_W-1:0]  RST_VAL   = '0
) (
   input  logic                       s_axi_aclk,
   input  logic                       s_axi_areset,
   input  logic [ADDR_W-1:0]          s_axi_awaddr,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   input  logic [DATA_W-1:0]          s_axi_wdata,
   input  logic [DATA_W/8-1:0]        s_axi_wstrb,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   input  logic [ADDR_W-1:0]          s_axi_araddr,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   output logic [DATA_W-1:0]          s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   output logic [N_REGS*DATA_W-1:0]   reg_o,
   output logic [N_REGS-1:0]          reg_wr_pulse_o,
   input  logic [N_REGS*DATA_W-1:0]   hw_status_i
);

   localparam int STRB_W = DATA_W / 8;
   localparam int SHIFT  = $clog2(STRB_W);
   localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [ADDR_W-1:0] N_REGS_A    = ADDR_W'(N_REGS);
   localparam logic [1:0]        RESP_OKAY   = 2'b00;
   localparam logic [1:0]        RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   function automatic logic [ADDR_W-1:0] slot_of(input logic [ADDR_W-1:0] addr);
      return (addr - BASE_ADDR) >> SHIFT;
   endfunction

   w_state_t            w_state_q, w_state_d;
   logic                aw_held_q, aw_held_d;
   logic                w_held_q, w_held_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [N_REGS-1:0]   pulse_q, pulse_d;
   logic [DATA_W-1:0]   reg_q [N_REGS];
   logic [DATA_W-1:0]   reg_d [N_REGS];

   r_state_t            r_state_q, r_state_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;

   logic                aw_hs, w_hs, w_commit, w_in_rng, w_ok, w_err;
   logic [ADDR_W-1:0]   w_addr, w_slot;
   logic [DATA_W-1:0]   w_data;
   logic [STRB_W-1:0]   w_strb;
   logic [IDX_W-1:0]    w_idx;
   logic                ar_hs, r_in_rng, r_err;
   logic [ADDR_W-1:0]   r_slot;
   logic [IDX_W-1:0]    r_idx;

   assign s_axi_awready = (w_state_q == W_IDLE) && !aw_held_q;
   assign s_axi_wready  = (w_state_q == W_IDLE) && !w_held_q;
   assign s_axi_bvalid  = (w_state_q == W_RESP);
   assign s_axi_bresp   = bresp_q;
   assign aw_hs         = s_axi_awvalid && s_axi_awready;
   assign w_hs          = s_axi_wvalid && s_axi_wready;

   // A beat arriving this cycle is used directly so AW+W in one cycle commits without a bubble
   assign w_addr   = aw_held_q ? awaddr_q : s_axi_awaddr;
   assign w_data   = w_held_q ? wdata_q : s_axi_wdata;
   assign w_strb   = w_held_q ? wstrb_q : s_axi_wstrb;
   assign w_slot   = slot_of(w_addr);
   assign w_idx    = w_slot[IDX_W-1:0];
   assign w_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign w_in_rng = (w_addr >= BASE_ADDR) && (w_slot < N_REGS_A);
   assign w_ok     = w_in_rng && !RO_MASK[w_idx];

   assign s_axi_arready = (r_state_q == R_IDLE);
   assign s_axi_rvalid  = (r_state_q == R_RESP);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign ar_hs         = s_axi_arvalid && s_axi_arready;
   assign r_slot        = slot_of(s_axi_araddr);
   assign r_idx         = r_slot[IDX_W-1:0];
   assign r_in_rng      = (s_axi_araddr >= BASE_ADDR) && (r_slot < N_REGS_A);

`ifdef PCA_MMIO_ERRCNT_EN
   logic        w_cnt_hit, r_cnt_hit;
   logic [15:0] errcnt_q, errcnt_d;
   logic [16:0] errcnt_sum;

   assign w_cnt_hit = (w_addr >= BASE_ADDR) && (w_slot == N_REGS_A);
   assign r_cnt_hit = (s_axi_araddr >= BASE_ADDR) && (r_slot == N_REGS_A);
   assign w_err     = w_commit && !w_ok && !w_cnt_hit;
   assign r_err     = ar_hs && !r_in_rng && !r_cnt_hit;

   always_comb begin
      errcnt_sum = {1'b0, errcnt_q} + {16'b0, w_err} + {16'b0, r_err};
      errcnt_d   = (errcnt_sum > 17'h0FFFF) ? 16'hFFFF : errcnt_sum[15:0];
      if (w_commit && w_cnt_hit)
         errcnt_d = '0;
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) errcnt_q <= '0;
      else              errcnt_q <= errcnt_d;
   end
`else
   assign w_err = w_commit && !w_ok;
   assign r_err = ar_hs && !r_in_rng;
`endif

   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      pulse_d   = '0;
      for (int i = 0; i < N_REGS; i++) reg_d[i] = reg_q[i];
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = s_axi_awaddr;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = s_axi_wdata;
               wstrb_d  = s_axi_wstrb;
            end
            if (w_commit) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               w_state_d = W_RESP;
               bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
               if (w_ok) begin
                  pulse_d[w_idx] = 1'b1;
                  for (int b = 0; b < STRB_W; b++)
                     if (w_strb[b]) reg_d[w_idx][b*8 +: 8] = w_data[b*8 +: 8];
               end
            end
         end
         W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               rdata_d   = '0;
               rresp_d   = r_err ? RESP_SLVERR : RESP_OKAY;
               if (r_in_rng)
                  rdata_d = RO_MASK[r_idx] ? hw_status_i[r_idx*DATA_W +: DATA_W] : reg_q[r_idx];
`ifdef PCA_MMIO_ERRCNT_EN
               if (r_cnt_hit)
                  rdata_d = DATA_W'(errcnt_q);
`endif
            end
         end
         R_RESP:  if (s_axi_rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         pulse_q   <= '0;
         for (int i = 0; i < N_REGS; i++) reg_q[i] <= RST_VAL;
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         pulse_q   <= pulse_d;
         for (int i = 0; i < N_REGS; i++) reg_q[i] <= reg_d[i];
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
      assign reg_o[g*DATA_W +: DATA_W] = reg_q[g];
   end
   assign reg_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_pca_axi_mmio_regbank.sv
// Directed bench for pca_axi_mmio_regbank with a slot-level reference model checked every cycle.
module tb_pca_axi_mmio_regbank;

   localparam int          N    = 16;
   localparam logic [31:0] RSTV = 32'h5A5A_0001;
   localparam logic [15:0] ROM  = 16'h0001;

   logic          clk, rst;
   logic [31:0]   awaddr, wdata, araddr, rdata;
   logic [3:0]    wstrb;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [1:0]    bresp, rresp;
   logic [N*32-1:0] reg_o, hw_status;
   logic [N-1:0]  pulse;

   pca_axi_mmio_regbank #(
      .ADDR_W(32), .DATA_W(32), .N_REGS(N), .BASE_ADDR(32'h0),
      .RO_MASK(ROM), .RST_VAL(RSTV)
   ) dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_o(reg_o), .reg_wr_pulse_o(pulse), .hw_status_i(hw_status)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: slot contents, error count, and the transaction each driver has in flight
   logic [31:0] m_reg [N];
   int          m_cnt;
   logic [31:0] pend_waddr, pend_wdata, pend_raddr;
   logic [3:0]  pend_wstrb;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_reg[i] = RSTV;
      m_cnt = 0;
   endtask

   task automatic predict_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                output logic [1:0] resp, output logic [N-1:0] pv);
      int unsigned slot;
      slot = a >> 2;
      pv   = '0;
      resp = 2'b00;
      if (slot < N && ROM[slot] == 1'b0) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_reg[slot][b*8 +: 8] = d[b*8 +: 8];
         pv[slot] = 1'b1;
      end
`ifdef PCA_MMIO_ERRCNT_EN
      else if (slot == N) m_cnt = 0;
`endif
      else begin
         resp = 2'b10;
         if (m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic predict_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int unsigned slot;
      slot = a >> 2;
      d    = '0;
      resp = 2'b00;
      if (slot < N) d = ROM[slot] ? hw_status[slot*32 +: 32] : m_reg[slot];
`ifdef PCA_MMIO_ERRCNT_EN
      else if (slot == N) d = 32'(m_cnt);
`endif
      else begin
         resp = 2'b10;
         if (m_cnt < 65535) m_cnt++;
      end
   endtask

   logic          bvalid_p, rvalid_p;
   logic [31:0]   exp_rdata;
   logic [1:0]    exp_rresp, exp_bresp;
   logic [N-1:0]  exp_pulse;

   always @(negedge clk) begin
      if (rst) begin
         model_reset();
         bvalid_p = 1'b0;
         rvalid_p = 1'b0;
      end else begin
         exp_pulse = '0;
         if (rvalid && !rvalid_p) predict_read(pend_raddr, exp_rdata, exp_rresp);
         if (bvalid && !bvalid_p) predict_write(pend_waddr, pend_wdata, pend_wstrb, exp_bresp, exp_pulse);
         if (rvalid) begin
            chk("mdl_rdata", rdata, exp_rdata);
            chk("mdl_rresp", rresp, exp_rresp);
         end
         if (bvalid) chk("mdl_bresp", bresp, exp_bresp);
         chk("mdl_pulse", pulse, exp_pulse);
         for (int i = 0; i < N; i++) chk($sformatf("mdl_reg_o[%0d]", i), reg_o[i*32 +: 32], m_reg[i]);
         bvalid_p = bvalid;
         rvalid_p = rvalid;
      end
   end

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int b_hold, output logic [1:0] resp);
      bit aw_done, w_done, aw_acc, w_acc;
      int cyc, waited;
      aw_done = 0; w_done = 0; cyc = 0;
      pend_waddr = a; pend_wdata = d; pend_wstrb = s;
      awaddr = a; wdata = d; wstrb = s;
      wvalid = 1'b1;
      awvalid = (w_lead == 0);
      while (!(aw_done && w_done) && cyc < 50) begin
         @(negedge clk);
         if (w_lead > 0 && w_done && !aw_done) begin
            chk("w_first_wready_low", wready, 1'b0);
            chk("w_first_no_bvalid", bvalid, 1'b0);
         end
         aw_acc = awvalid && awready;
         w_acc  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_acc) begin awvalid = 1'b0; aw_done = 1; end
         if (w_acc)  begin wvalid = 1'b0;  w_done = 1;  end
         cyc++;
         if (cyc >= w_lead && !aw_done) awvalid = 1'b1;
      end
      if (!(aw_done && w_done)) chk("wr_accept_timeout", 0, 1);
      waited = 0;
      @(negedge clk);
      while (!bvalid && waited < 20) begin waited++; @(negedge clk); end
      chk("b_latency", waited, 0);
      for (int k = 0; k < b_hold; k++) begin
         chk("b_hold_awready", awready, 1'b0);
         chk("b_hold_wready", wready, 1'b0);
         @(negedge clk);
         chk("b_hold_bvalid", bvalid, 1'b1);
      end
      resp = bresp;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("b_done", bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [31:0] a, input int r_hold,
                           output logic [31:0] d, output logic [1:0] resp);
      bit acc, acc_now;
      int cyc, waited;
      acc = 0; cyc = 0;
      pend_raddr = a;
      araddr = a;
      arvalid = 1'b1;
      while (!acc && cyc < 50) begin
         @(negedge clk);
         acc_now = arready;
         @(posedge clk); #1;
         if (acc_now) begin arvalid = 1'b0; acc = 1; end
         cyc++;
      end
      if (!acc) chk("rd_accept_timeout", 0, 1);
      waited = 0;
      @(negedge clk);
      while (!rvalid && waited < 20) begin waited++; @(negedge clk); end
      chk("r_latency", waited, 0);
      for (int k = 0; k < r_hold; k++) begin
         chk("r_hold_arready", arready, 1'b0);
         @(negedge clk);
      end
      d = rdata;
      resp = rresp;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      chk("r_done", rvalid, 1'b0);
   endtask

   logic [31:0] rd, rd2;
   logic [1:0]  rs, rs2;

   initial begin
      rst = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      pend_waddr = '0; pend_wdata = '0; pend_wstrb = '0; pend_raddr = '0;
      for (int i = 0; i < N; i++) hw_status[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      hw_status[31:0] = 32'hCAFE_F00D;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_awready", awready, 1'b1);
      chk("rst_wready", wready, 1'b1);
      chk("rst_arready", arready, 1'b1);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rresp", rresp, 2'b00);
      chk("rst_bresp", bresp, 2'b00);
      chk("rst_pulse", pulse, 16'h0);
      chk("rst_reg_o5", reg_o[5*32 +: 32], RSTV);
      rst = 1'b0;
      @(posedge clk); #1;

      axi_write(32'h8, 32'hA5A5_1234, 4'hF, 0, 0, rs);
      chk("wr_slot2_resp", rs, 2'b00);
      chk("wr_slot2_reg_o", reg_o[2*32 +: 32], 32'hA5A5_1234);
      axi_read(32'h8, 0, rd, rs);
      chk("rd_slot2_data", rd, 32'hA5A5_1234);
      chk("rd_slot2_resp", rs, 2'b00);

      axi_write(32'h4, 32'h1111_1111, 4'hF, 0, 0, rs);
      axi_write(32'h4, 32'hFFFF_FFFF, 4'h5, 0, 0, rs);
      axi_read(32'h4, 0, rd, rs);
      chk("strobe_merge", rd, 32'h11FF_11FF);

      axi_write(32'hC, 32'h0BAD_BEEF, 4'hF, 3, 4, rs);
      chk("w_first_resp", rs, 2'b00);
      chk("w_first_reg_o", reg_o[3*32 +: 32], 32'h0BAD_BEEF);

      axi_read(32'h0, 0, rd, rs);
      chk("ro_rd_data", rd, 32'hCAFE_F00D);
      chk("ro_rd_resp", rs, 2'b00);
      axi_write(32'h0, 32'h1234_5678, 4'hF, 0, 0, rs);
      chk("ro_wr_resp", rs, 2'b10);
      chk("ro_wr_reg_o", reg_o[31:0], RSTV);

      axi_write(32'h3C, 32'hDEAD_BEEF, 4'hF, 0, 0, rs);
      chk("last_slot_resp", rs, 2'b00);
      axi_write(32'h3F, 32'h1234_5678, 4'h0, 0, 0, rs);
      chk("strb0_resp", rs, 2'b00);
      axi_read(32'h3D, 3, rd, rs);
      chk("strb0_unchanged", rd, 32'hDEAD_BEEF);

`ifdef PCA_MMIO_ERRCNT_EN
      axi_write(32'h40, 32'h0, 4'hF, 0, 0, rs);
      chk("cnt_clr_resp", rs, 2'b00);
      axi_read(32'h44, 0, rd, rs);
      chk("oor_rd_resp", rs, 2'b10);
      chk("oor_rd_data", rd, 32'h0);
      axi_read(32'h40, 0, rd, rs);
      chk("cnt_rd_resp", rs, 2'b00);
      chk("cnt_rd_one", rd, 32'h1);
      axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, rs);
      axi_read(32'h40, 0, rd, rs);
      chk("cnt_rd_cleared", rd, 32'h0);
`else
      axi_read(32'h40, 0, rd, rs);
      chk("oor_rd_resp", rs, 2'b10);
      chk("oor_rd_data", rd, 32'h0);
      axi_write(32'h40, 32'h1, 4'hF, 0, 0, rs);
      chk("oor_wr_resp", rs, 2'b10);
`endif

      axi_read(32'h9, 0, rd, rs);
      chk("byte_offset_rd", rd, 32'hA5A5_1234);

      fork
         axi_write(32'h8, 32'h7777_8888, 4'hF, 0, 0, rs2);
         axi_read(32'h8, 0, rd2, rs);
      join
      chk("rw_same_cycle_old", rd2, 32'hA5A5_1234);
      axi_read(32'h8, 0, rd, rs);
      chk("rw_same_cycle_new", rd, 32'h7777_8888);

      pend_raddr = 32'h8;
      araddr = 32'h8;
      arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      chk("pre_rst_rvalid", rvalid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_rvalid", rvalid, 1'b0);
      chk("mid_rst_arready", arready, 1'b1);
      chk("mid_rst_awready", awready, 1'b1);
      for (int i = 0; i < N; i++) chk($sformatf("mid_rst_reg_o[%0d]", i), reg_o[i*32 +: 32], RSTV);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      axi_read(32'h8, 0, rd, rs);
      chk("post_rst_rd", rd, RSTV);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pca_axi_mmio_regbank.md
Name: pca_axi_mmio_regbank

Overview:
- Parametrised AXI-Lite slave register bank. Next generation of the PCA AXI MMIO bridge: width, depth and base address are configurable, and the block terminates transactions itself with strobe merge, range and read-only decode, and per-register write pulses.
- Sits behind the block-design AXI-Lite interconnect.
- Exposes N_REGS control registers to PL logic and returns N_REGS hardware status words to software.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; legal values are 32 or 64. Strobe width is DATA_W/8.
- N_REGS, 16, number of register slots; range 1..256.
- BASE_ADDR, 0, byte address of slot 0. Must be aligned to DATA_W/8.
- RO_MASK, 0 (N_REGS bits), bit i=1 makes slot i read-only. A read-only slot reads hw_status_i slice i.
- RST_VAL, 0 (DATA_W bits), reset value of every writable slot.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  asynchronous reset, active-high
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1 / s_axi_awready  out  1
- s_axi_wdata  in  DATA_W / s_axi_wstrb  in  DATA_W/8 / s_axi_wvalid  in  1 / s_axi_wready  out  1
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1
- s_axi_araddr  in  ADDR_W / s_axi_arvalid  in  1 / s_axi_arready  out  1
- s_axi_rdata  out  DATA_W / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1
- reg_o  out  N_REGS*DATA_W  current writable-slot values; slot i is at bits [i*DATA_W +: DATA_W]
- reg_wr_pulse_o  out  N_REGS  one-cycle pulse when slot i is written successfully
- hw_status_i  in  N_REGS*DATA_W  read-only slot sources (synchronous to s_axi_aclk)

Behaviour:
- Reset values (async assert, sync release):
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - reg_o slices=RST_VAL; reg_wr_pulse_o=0.
- Decode:
  - idx = (addr - BASE_ADDR) >> log2(DATA_W/8). Byte-offset bits are ignored.
  - An address is in range iff addr >= BASE_ADDR and idx < N_REGS.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle.
  - awready drops after AW is captured; wready drops after W is captured.
  - In the cycle both are held, the write commits:
    - Each byte lane with wstrb=1 is updated.
    - reg_wr_pulse_o[idx] pulses in the following cycle.
  - FSM then moves to W_RESP with bvalid=1. bvalid holds until bready.
  - On B handshake, return to W_IDLE; awready and wready go high again.
  - bresp=OKAY for an in-range writable slot.
  - bresp=SLVERR (2'b10) for out-of-range or read-only targets; no register changes and no pulse.
  - wstrb=0 to a valid slot: OKAY, no change, pulse still asserted.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. On the AR handshake, rdata is captured and rvalid=1 on the next cycle.
  - rdata and rresp are held stable until rready.
  - rresp=OKAY when in range. Out of range gives SLVERR with rdata=0.
  - A read-only slot returns hw_status_i sampled on the AR handshake cycle.
- Minimum latency: AW+W to bvalid is 1 cycle; AR to rvalid is 1 cycle. Throughput is one transaction per 2 cycles per channel.
- Read and write to the same slot in the same cycle: the read returns the pre-write value.
- Read and write channels are fully independent; there is no arbitration stall.
- Reset mid-transaction: FSMs return to IDLE immediately, pending responses are dropped, registers go to RST_VAL.

Optional Feature:
- Macro PCA_MMIO_ERRCNT_EN.
- Defined:
  - Adds a 16-bit error counter at slot index N_REGS, zero-extended to DATA_W.
  - The counter increments on every SLVERR response, read or write, and saturates at 0xFFFF.
  - Reads of slot N_REGS return OKAY with the count.
  - Any write to slot N_REGS clears the count and returns OKAY. If an SLVERR occurs in the same cycle, the clear wins.
  - Reset value is 0.
- Undefined: slot N_REGS is out of range and returns SLVERR. No counter logic is built.

Test Plan:
- Defaults: write 0xA5A5_1234 to 0x8 with wstrb=0xF -> bresp=OKAY, reg_o[2]=0xA5A5_1234, reg_wr_pulse_o[2] pulses for 1 cycle. Read 0x8 -> rdata=0xA5A5_1234, OKAY.
- Strobe merge: slot 1=0x1111_1111, then write 0xFFFF_FFFF with wstrb=0x5 -> readback 0x11FF_11FF.
- W asserted 3 cycles before AW; bready held low for 4 cycles -> a single commit on AW arrival, bvalid stays high with stable bresp until bready, awready/wready low meanwhile.
- RO_MASK=0x1, hw_status_i slot 0=0xCAFE_F00D: read 0x0 -> 0xCAFE_F00D OKAY. Write 0x0 -> SLVERR, no pulse.
- Read 0x40 with N_REGS=16 -> SLVERR, rdata=0. With PCA_MMIO_ERRCNT_EN, a read of 0x40 returns count 1 (counting that SLVERR). A write to 0x40 clears it, and a following read returns 0.
- Assert s_axi_areset while rvalid=1 and rready=0 -> rvalid=0 and arready=1 immediately, all reg_o slices=RST_VAL.
